ballot_unit: RTL

BALLOT_UNIT -- requirements
Module: ballot_unit

---
 rtl/ballot_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ballot_unit.sv
// rtl/ballot_unit.sv - voting-session FSM: voter ID check, candidate selection, one-shot vote strobe.
// Optional SELECT inactivity timeout enabled by defining BALLOT_TIMEOUT_EN.
module ballot_unit #(
    parameter int NUM_CANDIDATES = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] id_in,
    input  logic       id_load,
    input  logic [3:0] cand_in,
    input  logic       cand_sel,
    input  logic       confirm,
    input  logic       cancel,
    output logic [3:0] voter_id,
    output logic [3:0] candidate_number,
    output logic       vote_cast,
    output logic       busy,
    output logic       reject,
    output logic [7:0] votes_issued
);

    typedef enum logic [1:0] {S_IDLE, S_SELECT, S_CAST, S_GAP} state_t;

    localparam logic [4:0] NUM_CAND = 5'(NUM_CANDIDATES);

    if (NUM_CANDIDATES < 1 || NUM_CANDIDATES > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
        $error("ballot_unit: parameter out of range");
    end

    state_t      state_q, state_d;
    logic [3:0]  voter_id_q, voter_id_d;
    logic [3:0]  cand_q, cand_d;
    logic        cand_valid_q, cand_valid_d;
    logic [15:0] voted_q, voted_d;
    logic [7:0]  votes_q, votes_d;
    logic        vote_cast_q, vote_cast_d;
    logic        busy_q, busy_d;
    logic        reject_q, reject_d;
    logic        cand_ok;
`ifdef BALLOT_TIMEOUT_EN
    localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic [7:0]  tmo_next;
`endif

    assign cand_ok = {1'b0, cand_in} < NUM_CAND;

    always_comb begin
        state_d      = state_q;
        voter_id_d   = voter_id_q;
        cand_d       = cand_q;
        cand_valid_d = cand_valid_q;
        voted_d      = voted_q;
        votes_d      = votes_q;
        reject_d     = 1'b0;
`ifdef BALLOT_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        tmo_next     = 8'(tmo_cnt_q + 8'd1);
`endif
        case (state_q)
            S_IDLE: begin
                if (id_load) begin
                    if (voted_q[id_in]) begin
                        reject_d = 1'b1;
                    end else begin
                        voter_id_d   = id_in;
                        cand_valid_d = 1'b0;
                        state_d      = S_SELECT;
`ifdef BALLOT_TIMEOUT_EN
                        tmo_cnt_d    = 8'd0;
`endif
                    end
                end
            end
            S_SELECT: begin
                if (cancel) begin
                    state_d = S_IDLE;
                end else begin
                    if (cand_sel) begin
                        if (cand_ok) begin
                            cand_d       = cand_in;
                            cand_valid_d = 1'b1;
                        end else begin
                            reject_d = 1'b1;
                        end
                    end
                    // The vote is committed on the edge entering CAST so the strobe and count land together.
                    if (confirm && cand_valid_q) begin
                        state_d             = S_CAST;
                        voted_d[voter_id_q] = 1'b1;
                        if (votes_q != 8'hFF) begin
                            votes_d = 8'(votes_q + 8'd1);
                        end
                    end
`ifdef BALLOT_TIMEOUT_EN
                    if (cand_sel || confirm) begin
                        tmo_cnt_d = 8'd0;
                    end else if (tmo_next == TMO) begin
                        reject_d = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        tmo_cnt_d = tmo_next;
                    end
`endif
                end
            end
            S_CAST:  state_d = S_GAP;
            default: state_d = S_IDLE;
        endcase
        vote_cast_d = (state_d == S_CAST);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            voter_id_q   <= 4'd0;
            cand_q       <= 4'd0;
            cand_valid_q <= 1'b0;
            voted_q      <= 16'd0;
            votes_q      <= 8'd0;
            vote_cast_q  <= 1'b0;
            busy_q       <= 1'b0;
            reject_q     <= 1'b0;
`ifdef BALLOT_TIMEOUT_EN
            tmo_cnt_q    <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            voter_id_q   <= voter_id_d;
            cand_q       <= cand_d;
            cand_valid_q <= cand_valid_d;
            voted_q      <= voted_d;
            votes_q      <= votes_d;
            vote_cast_q  <= vote_cast_d;
            busy_q       <= busy_d;
            reject_q     <= reject_d;
`ifdef BALLOT_TIMEOUT_EN
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign voter_id         = voter_id_q;
    assign candidate_number = cand_q;
    assign vote_cast        = vote_cast_q;
    assign busy             = busy_q;
    assign reject           = reject_q;
    assign votes_issued     = votes_q;

endmodule
